// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (IFU, LSU), the arbiter and the memory port.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              m0_req_valid;
    logic              m0_req_ready;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_wen;
    logic [DATA_W-1:0] m0_wdata;
    logic [MASK_W-1:0] m0_wmask;
    logic              m0_resp_valid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_resp_err;

    logic              m1_req_valid;
    logic              m1_req_ready;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_wen;
    logic [DATA_W-1:0] m1_wdata;
    logic [MASK_W-1:0] m1_wmask;
    logic              m1_resp_valid;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_resp_err;

    logic              s_req_valid;
    logic              s_req_ready;
    logic [ADDR_W-1:0] s_addr;
    logic              s_wen;
    logic [DATA_W-1:0] s_wdata;
    logic [MASK_W-1:0] s_wmask;
    logic              s_resp_valid;
    logic [DATA_W-1:0] s_rdata;

    modport slave (
        input  m0_req_valid, m0_addr, m0_wen, m0_wdata, m0_wmask,
        output m0_req_ready, m0_resp_valid, m0_rdata, m0_resp_err,
        input  m1_req_valid, m1_addr, m1_wen, m1_wdata, m1_wmask,
        output m1_req_ready, m1_resp_valid, m1_rdata, m1_resp_err,
        output s_req_valid, s_addr, s_wen, s_wdata, s_wmask,
        input  s_req_ready, s_resp_valid, s_rdata
    );

    modport master (
        output m0_req_valid, m0_addr, m0_wen, m0_wdata, m0_wmask,
        input  m0_req_ready, m0_resp_valid, m0_rdata, m0_resp_err,
        output m1_req_valid, m1_addr, m1_wen, m1_wdata, m1_wmask,
        input  m1_req_ready, m1_resp_valid, m1_rdata, m1_resp_err,
        input  s_req_valid, s_addr, s_wen, s_wdata, s_wmask,
        output s_req_ready, s_resp_valid, s_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (M0) and LSU (M1).
// One transaction in flight; the request is registered toward memory and a watchdog forces an error response.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_s_req_valid;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic [WDOG_W-1:0] r_wdog;

    logic w_gnt;
    logic w_accept;
    logic w_timeout;
    logic w_resp;

    // Grant selection and response qualification
    always_comb begin
        w_gnt     = bus.m1_req_valid;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        w_resp    = 1'b0;
        if (bus.m0_req_valid && bus.m1_req_valid) begin
            w_gnt = !r_last_grant;
        end
        if (r_state == IDLE) begin
            w_accept = bus.m0_req_valid || bus.m1_req_valid;
        end
        if (r_state == WAIT) begin
            w_timeout = (TIMEOUT != 32'd0) && !bus.s_resp_valid
                        && (r_wdog == WDOG_W'(TIMEOUT - 32'd1));
            w_resp    = bus.s_resp_valid || w_timeout;
        end
    end

    assign bus.m0_req_ready  = (r_state == IDLE) && bus.m0_req_valid && !w_gnt;
    assign bus.m1_req_ready  = (r_state == IDLE) && bus.m1_req_valid && w_gnt;
    assign bus.m0_resp_valid = w_resp && !r_owner;
    assign bus.m1_resp_valid = w_resp && r_owner;
    assign bus.m0_resp_err   = w_timeout && !r_owner;
    assign bus.m1_resp_err   = w_timeout && r_owner;
    assign bus.m0_rdata      = w_timeout ? '0 : bus.s_rdata;
    assign bus.m1_rdata      = w_timeout ? '0 : bus.s_rdata;

    assign bus.s_req_valid   = r_s_req_valid;
    assign bus.s_addr        = r_addr;
    assign bus.s_wen         = r_wen;
    assign bus.s_wdata       = r_wdata;
    assign bus.s_wmask       = r_wmask;

    // Transaction FSM; the request bundle only loads in IDLE so it stays stable through REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_s_req_valid <= 1'b0;
            r_addr        <= '0;
            r_wen         <= 1'b0;
            r_wdata       <= '0;
            r_wmask       <= '0;
            r_wdog        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner       <= w_gnt;
                        r_last_grant  <= w_gnt;
                        r_s_req_valid <= 1'b1;
                        r_state       <= REQ;
                        if (w_gnt) begin
                            r_addr  <= bus.m1_addr;
                            r_wen   <= bus.m1_wen;
                            r_wdata <= bus.m1_wdata;
                            r_wmask <= bus.m1_wmask;
                        end else begin
                            r_addr  <= bus.m0_addr;
                            r_wen   <= bus.m0_wen;
                            r_wdata <= bus.m0_wdata;
                            r_wmask <= bus.m0_wmask;
                        end
                    end
                end
                REQ: begin
                    if (bus.s_req_ready) begin
                        r_s_req_valid <= 1'b0;
                        r_wdog        <= '0;
                        r_state       <= WAIT;
                    end
                end
                WAIT: begin
                    r_wdog <= r_wdog + WDOG_W'(1);
                    if (w_resp) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the grant, hold, response and watchdog rules.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Memory model knobs and state; it takes requests and answers sl_delay cycles after the handshake edge
    int          sl_stall = 0, sl_delay = 2, sl_stall_left = 0, sl_cnt = 0;
    bit          sl_mute = 0, sl_rand = 0, sl_stray = 0, sl_fixed_en = 0;
    bit          sl_inreq = 0, sl_pend = 0, sl_hs = 0, sl_resp_now = 0;
    logic [31:0] sl_fixed_rdata = '0, sl_resp_data = '0;

    initial begin
        bus.s_req_ready = 1'b0; bus.s_resp_valid = 1'b0; bus.s_rdata = '0;
        forever begin
            @(negedge clk);
            sl_resp_now = 0; sl_hs = 0;
            if (sl_pend) begin
                sl_cnt--;
                if (sl_cnt <= 0) begin sl_pend = 0; sl_resp_now = 1; end
            end else if (sl_stray && ($urandom_range(7, 0) == 0)) begin
                sl_resp_now = 1;
            end
            if (bus.s_req_valid === 1'b1) begin
                if (!sl_inreq) begin
                    sl_inreq = 1;
                    sl_stall_left = sl_rand ? int'($urandom_range(2, 0)) : sl_stall;
                end
                if (sl_stall_left > 0) sl_stall_left--;
                else begin
                    sl_inreq = 0; sl_hs = 1;
                    if (!sl_mute) begin
                        sl_pend = 1;
                        sl_cnt  = sl_rand ? int'($urandom_range(9, 1)) : sl_delay;
                    end
                end
            end
            sl_resp_data     = sl_fixed_en ? sl_fixed_rdata : $urandom;
            bus.s_req_ready  = sl_hs;
            bus.s_resp_valid = sl_resp_now;
            bus.s_rdata      = sl_resp_data;
        end
    end

    task automatic drive_m(input int k, input logic v, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] m);
        if (k == 0) begin
            bus.m0_req_valid = v; bus.m0_addr = a; bus.m0_wen = w; bus.m0_wdata = d; bus.m0_wmask = m;
        end else begin
            bus.m1_req_valid = v; bus.m1_addr = a; bus.m1_wen = w; bus.m1_wdata = d; bus.m1_wmask = m;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_m(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        drive_m(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sl_stall = 0; sl_delay = 2; sl_mute = 0; sl_rand = 0; sl_stray = 0; sl_fixed_en = 0;
        sl_inreq = 0; sl_pend = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.m0_req_ready, bus.m1_req_ready, bus.m0_resp_valid, bus.m1_resp_valid, bus.s_req_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_valids got=%b exp=00000", {bus.m0_req_ready, bus.m1_req_ready,
                     bus.m0_resp_valid, bus.m1_resp_valid, bus.s_req_valid});
        end
        checks++;
        if ({bus.s_addr, bus.s_wen, bus.s_wdata, bus.s_wmask} !== 69'h0) begin
            errors++;
            $display("FAIL reset_req_regs got=%h exp=0", {bus.s_addr, bus.s_wen, bus.s_wdata, bus.s_wmask});
        end
        @(negedge clk);
        drive_m(0, 1'b1, 32'h1000, 1'b0, 32'h0, 4'h0);
        drive_m(1, 1'b1, 32'h2000, 1'b0, 32'h0, 4'h0);
        #1;
        checks++;
        if ({bus.m0_req_ready, bus.m1_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_tie got=%b exp=10", {bus.m0_req_ready, bus.m1_req_ready});
        end
    endtask

    task automatic test_single_read();
        bit acc = 0, m1_act = 0;
        int n0 = 0;
        logic [31:0] rd = '0;
        logic er = 1'b0;
        do_reset();
        sl_fixed_en = 1; sl_fixed_rdata = 32'h0010_0073; sl_delay = 2;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive_m(0, !acc, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
            #1;
            if (bus.m1_req_ready || bus.m1_resp_valid) m1_act = 1;
            if (bus.s_req_valid && bus.s_req_ready) begin
                checks++;
                if ({bus.s_addr, bus.s_wen} !== {32'h8000_0000, 1'b0}) begin
                    errors++;
                    $display("FAIL read_s_req got=%h/%b exp=80000000/0", bus.s_addr, bus.s_wen);
                end
            end
            if (bus.m0_resp_valid) begin n0++; rd = bus.m0_rdata; er = bus.m0_resp_err; end
            if (bus.m0_req_ready) acc = 1;
        end
        checks++; if (!acc)    begin errors++; $display("FAIL read_accept got=0 exp=1"); end
        checks++; if (n0 != 1) begin errors++; $display("FAIL read_resp_count got=%0d exp=1", n0); end
        checks++;
        if (rd !== 32'h0010_0073) begin errors++; $display("FAIL read_rdata got=%h exp=00100073", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_err got=%b exp=0", er); end
        checks++; if (m1_act) begin errors++; $display("FAIL read_m1_quiet got=1 exp=0"); end
    endtask

    task automatic test_tie();
        int order[$];
        logic [31:0] a0, a1;
        do_reset();
        a0 = $urandom; a1 = $urandom;
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            @(negedge clk);
            drive_m(0, 1'b1, a0, 1'b0, 32'h0, 4'h0);
            drive_m(1, 1'b1, a1, 1'b0, 32'h0, 4'h0);
            #1;
            checks++;
            if (bus.m0_req_ready && bus.m1_req_ready) begin
                errors++; $display("FAIL tie_both_ready got=11 exp=one-hot");
            end
            if (bus.m0_req_ready) begin order.push_back(0); a0 = $urandom; end
            else if (bus.m1_req_ready) begin order.push_back(1); a1 = $urandom; end
        end
        checks++;
        if (order.size() != 4) begin errors++; $display("FAIL tie_count got=%0d exp=4", order.size()); end
        foreach (order[i]) begin
            checks++;
            if (order[i] != i % 2) begin
                errors++; $display("FAIL tie_order[%0d] got=M%0d exp=M%0d", i, order[i], i % 2);
            end
        end
    endtask

    task automatic test_write_stall();
        bit acc = 0, m0_act = 0;
        int stalls = 0, n1 = 0;
        logic [68:0] exp_req = {32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011};
        do_reset();
        sl_stall = 3;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            drive_m(1, !acc, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011);
            #1;
            if (bus.s_req_valid) begin
                if (!bus.s_req_ready) stalls++;
                checks++;
                if ({bus.s_addr, bus.s_wen, bus.s_wdata, bus.s_wmask} !== exp_req) begin
                    errors++;
                    $display("FAIL write_hold got=%h exp=%h", {bus.s_addr, bus.s_wen, bus.s_wdata, bus.s_wmask}, exp_req);
                end
            end
            if (bus.m0_req_ready || bus.m0_resp_valid) m0_act = 1;
            if (bus.m1_resp_valid) begin
                n1++;
                checks++;
                if (bus.m1_resp_err !== 1'b0) begin errors++; $display("FAIL write_err got=1 exp=0"); end
            end
            if (bus.m1_req_ready) acc = 1;
        end
        checks++; if (stalls != 3) begin errors++; $display("FAIL write_stalls got=%0d exp=3", stalls); end
        checks++; if (n1 != 1) begin errors++; $display("FAIL write_resp_count got=%0d exp=1", n1); end
        checks++; if (m0_act) begin errors++; $display("FAIL write_m0_quiet got=1 exp=0"); end
    endtask

    task automatic test_timeout();
        bit acc = 0, acc2 = 0;
        int hs_c = -1, rsp_c = -1, n = 0;
        logic [31:0] rd = 32'hFFFF_FFFF;
        logic er = 1'b0;
        do_reset();
        sl_mute = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            drive_m(0, !acc || (rsp_c >= 0), 32'h8000_0040, 1'b0, 32'h0, 4'h0);
            #1;
            if (rsp_c >= 0) begin
                checks++;
                if (bus.m0_req_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle got=0 exp=1"); end
                acc2 = 1;
                break;
            end
            if (bus.m0_req_ready) acc = 1;
            if (bus.s_req_valid && bus.s_req_ready) hs_c = c;
            if (bus.m0_resp_valid) begin n++; rsp_c = c; rd = bus.m0_rdata; er = bus.m0_resp_err; end
        end
        checks++; if (!acc2) begin errors++; $display("FAIL timeout_bound got=no-response exp=response"); end
        checks++; if (n != 1) begin errors++; $display("FAIL timeout_count got=%0d exp=1", n); end
        checks++;
        if (rsp_c - hs_c != int'(TO)) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", rsp_c - hs_c, TO); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL timeout_rdata got=%h exp=0", rd); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL timeout_err got=%b exp=1", er); end
    endtask

    task automatic test_reset_mid();
        bit acc = 0, hs = 0, quiet = 1, late = 0;
        do_reset();
        sl_delay = 6;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive_m(0, !acc, 32'h8000_0080, 1'b0, 32'h0, 4'h0);
            #1;
            if (bus.m0_req_ready) acc = 1;
            if (bus.s_req_valid && bus.s_req_ready) begin hs = 1; break; end
        end
        checks++; if (!hs) begin errors++; $display("FAIL midrst_handshake got=0 exp=1"); end
        @(negedge clk);
        drive_m(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.s_req_valid, bus.m0_req_ready, bus.m1_req_ready} !== 3'b000) begin
            errors++; $display("FAIL midrst_idle got=%b exp=000", {bus.s_req_valid, bus.m0_req_ready, bus.m1_req_ready});
        end
        for (int c = 0; c < 8; c++) begin
            if (bus.m0_resp_valid || bus.m1_resp_valid) quiet = 0;
            if (bus.s_resp_valid) late = 1;
            @(negedge clk);
            #1;
        end
        checks++;
        if (!(quiet && late)) begin
            errors++; $display("FAIL midrst_no_resp got=quiet:%0d late:%0d exp=quiet:1 late:1", quiet, late);
        end
        @(negedge clk);
        drive_m(0, 1'b1, 32'h1, 1'b0, 32'h0, 4'h0);
        drive_m(1, 1'b1, 32'h2, 1'b0, 32'h0, 4'h0);
        #1;
        checks++;
        if ({bus.m0_req_ready, bus.m1_req_ready} !== 2'b10) begin
            errors++; $display("FAIL midrst_tie got=%b exp=10", {bus.m0_req_ready, bus.m1_req_ready});
        end
    endtask

    task automatic test_back_to_back();
        int acc_c[$];
        logic [31:0] addr_q[$];
        logic [31:0] a0;
        do_reset();
        a0 = $urandom;
        for (int c = 0; c < 60 && acc_c.size() < 6; c++) begin
            @(negedge clk);
            drive_m(0, 1'b1, a0, 1'b0, 32'h0, 4'h0);
            #1;
            if (bus.s_req_valid && bus.s_req_ready) begin
                checks++;
                if (addr_q.size() == 0 || bus.s_addr !== addr_q[0]) begin
                    errors++; $display("FAIL b2b_issue_order got=%h exp=%h", bus.s_addr, (addr_q.size() != 0) ? addr_q[0] : 32'h0);
                end
                if (addr_q.size() != 0) void'(addr_q.pop_front());
            end
            if (bus.m0_resp_valid) begin
                checks++;
                if ({bus.m0_rdata, bus.m0_resp_err} !== {sl_resp_data, 1'b0}) begin
                    errors++; $display("FAIL b2b_resp got=%h/%b exp=%h/0", bus.m0_rdata, bus.m0_resp_err, sl_resp_data);
                end
            end
            if (bus.m0_req_ready) begin acc_c.push_back(c); addr_q.push_back(a0); a0 = $urandom; end
        end
        checks++;
        if (acc_c.size() != 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", acc_c.size()); end
        for (int i = 1; i < acc_c.size(); i++) begin
            checks++;
            if (acc_c[i] - acc_c[i-1] != 4) begin
                errors++; $display("FAIL b2b_interval[%0d] got=%0d exp=4", i, acc_c[i] - acc_c[i-1]);
            end
        end
    endtask

    task automatic test_random();
        bit          mv[2];
        logic [31:0] ma[2], md[2];
        logic        mw[2];
        logic [3:0]  mm[2];
        bit busy = 0, issued = 0, lastg = 1, owner = 0, g, er0, er1, exp_resp, exp_err;
        int waited = 0;
        logic [68:0] exp_req = '0;
        logic [31:0] exp_data;
        do_reset();
        sl_rand = 1; sl_stray = 1;
        mv[0] = 0; mv[1] = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!mv[k] && ($urandom_range(2, 0) == 0)) begin
                    mv[k] = 1; ma[k] = $urandom; md[k] = $urandom; mw[k] = 1'($urandom); mm[k] = 4'($urandom);
                end
                drive_m(k, mv[k], ma[k], mw[k], md[k], mm[k]);
            end
            #1;
            g = (mv[0] && mv[1]) ? !lastg : mv[1];
            er0 = !busy && mv[0] && !g;
            er1 = !busy && mv[1] && g;
            checks++;
            if ({bus.m0_req_ready, bus.m1_req_ready} !== {er0, er1}) begin
                errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, {bus.m0_req_ready, bus.m1_req_ready}, {er0, er1});
            end
            checks++;
            if (bus.s_req_valid !== (busy && !issued)) begin
                errors++; $display("FAIL rnd_s_req_valid c=%0d got=%b exp=%b", c, bus.s_req_valid, busy && !issued);
            end
            if (busy && !issued) begin
                checks++;
                if ({bus.s_addr, bus.s_wen, bus.s_wdata, bus.s_wmask} !== exp_req) begin
                    errors++; $display("FAIL rnd_s_hold c=%0d got=%h exp=%h", c, {bus.s_addr, bus.s_wen, bus.s_wdata, bus.s_wmask}, exp_req);
                end
            end
            exp_resp = busy && issued && (sl_resp_now || waited == int'(TO) - 1);
            exp_err  = exp_resp && !sl_resp_now;
            exp_data = exp_err ? 32'h0 : sl_resp_data;
            checks++;
            if ({bus.m0_resp_valid, bus.m1_resp_valid} !== {exp_resp && !owner, exp_resp && owner}) begin
                errors++; $display("FAIL rnd_resp_valid c=%0d got=%b exp=%b", c, {bus.m0_resp_valid, bus.m1_resp_valid},
                                   {exp_resp && !owner, exp_resp && owner});
            end
            if (exp_resp) begin
                checks++;
                if (owner ? ({bus.m1_rdata, bus.m1_resp_err} !== {exp_data, exp_err})
                          : ({bus.m0_rdata, bus.m0_resp_err} !== {exp_data, exp_err})) begin
                    errors++; $display("FAIL rnd_resp_data c=%0d got=%h/%b exp=%h/%b", c,
                                       owner ? bus.m1_rdata : bus.m0_rdata, owner ? bus.m1_resp_err : bus.m0_resp_err, exp_data, exp_err);
                end
            end
            if (busy && issued) begin
                if (exp_resp) busy = 0; else waited++;
            end else if (busy) begin
                if (sl_hs) begin issued = 1; waited = 0; end
            end else if (mv[0] || mv[1]) begin
                busy = 1; issued = 0; owner = g; lastg = g;
                exp_req = {ma[g], mw[g], md[g], mm[g]};
                mv[g] = 0;
            end
        end
    endtask

    initial begin
        bus.m0_req_valid = 1'b0; bus.m1_req_valid = 1'b0;
        test_reset();
        test_single_read();
        test_tie();
        test_write_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
